qspi_tx_shifter: RTL and testbench



---
 rtl/qspi_tx_shifter.sv | 169 ++++++++++++++++
 tb/tb_qspi_tx_shifter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_tx_shifter.sv
// Transmit serializer: pops 32-bit words from the TX FIFO and shifts them out
// on 1/2/4 QSPI lanes, byte 0 first and MSB first, with a mode-0 SCK.
module qspi_tx_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            lane_mode,
    input  logic [LEN_WIDTH-1:0]  byte_len,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  sck,
    output logic [3:0]            io_out,
    output logic [3:0]            io_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int            HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    state_t                 state_q, state_d;
    logic [1:0]             lsh_q, lsh_d;          // log2 of the lane count
    logic [LEN_WIDTH-1:0]   bytes_left_q, bytes_left_d;
    logic [31:0]            shreg_q, shreg_d;
    logic [5:0]             cyc_left_q, cyc_left_d;
    logic [HC_W-1:0]        hc_q, hc_d;
    logic                   sck_q, sck_d;
    logic [3:0]             io_q, io_d;

    logic [31:0]            stream;
    logic [2:0]             word_bytes;
    logic [5:0]             word_cycles;
    logic [2:0]             lanes;

    // Byte 0 is moved to the top so the serial stream always leaves from bit 31.
    assign stream      = {fifo_rd_data[7:0], fifo_rd_data[15:8],
                          fifo_rd_data[23:16], fifo_rd_data[31:24]};
    assign word_bytes  = (bytes_left_q >= LEN_WIDTH'(4)) ? 3'd4 : bytes_left_q[2:0];
    assign word_cycles = {word_bytes, 3'b000} >> lsh_q;
    assign lanes       = 3'd1 << lsh_q;

    function automatic logic [3:0] lane_bits(input logic [3:0] top, input logic [1:0] lsh);
        case (lsh)
            2'd0:    lane_bits = {3'b000, top[3]};
            2'd1:    lane_bits = {2'b00, top[3:2]};
            default: lane_bits = top;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case can infer a latch.
        state_d      = state_q;
        lsh_d        = lsh_q;
        bytes_left_d = bytes_left_q;
        shreg_d      = shreg_q;
        cyc_left_d   = cyc_left_q;
        hc_d         = hc_q;
        sck_d        = sck_q;
        io_d         = io_q;

        case (state_q)
            S_IDLE: begin
                io_d = 4'b0000;
                if (start && (byte_len != '0)) begin
                    lsh_d        = (lane_mode == 2'b11) ? 2'b00 : lane_mode;
                    bytes_left_d = byte_len;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!fifo_empty) state_d = S_WAIT;
            end
            S_WAIT: begin
                io_d         = lane_bits(stream[31:28], lsh_q);
                shreg_d      = stream << lanes;
                bytes_left_d = bytes_left_q - LEN_WIDTH'(word_bytes);
                cyc_left_d   = word_cycles;
                hc_d         = '0;
                sck_d        = 1'b0;
                state_d      = S_SHIFT;
            end
            S_SHIFT: begin
                if (hc_q == HC_LAST) begin
                    hc_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Falling edge: either the word is finished or the next bits go out now.
                        sck_d = 1'b0;
                        if (cyc_left_q == 6'd1) begin
                            state_d = (bytes_left_q == '0) ? S_DONE : S_FETCH;
                        end else begin
                            io_d       = lane_bits(shreg_q[31:28], lsh_q);
                            shreg_d    = shreg_q << lanes;
                            cyc_left_d = cyc_left_q - 6'd1;
                        end
                    end
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            S_DONE: begin
                io_d    = 4'b0000;
                state_d = S_IDLE;
            end
            default: begin
                io_d    = 4'b0000;
                sck_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lsh_q        <= 2'b00;
            bytes_left_q <= '0;
            shreg_q      <= '0;
            cyc_left_q   <= '0;
            hc_q         <= '0;
            sck_q        <= 1'b0;
            io_q         <= 4'b0000;
        end else begin
            state_q      <= state_d;
            lsh_q        <= lsh_d;
            bytes_left_q <= bytes_left_d;
            shreg_q      <= shreg_d;
            cyc_left_q   <= cyc_left_d;
            hc_q         <= hc_d;
            sck_q        <= sck_d;
            io_q         <= io_d;
        end
    end

    assign sck        = sck_q;
    assign io_out     = io_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fifo_rd_en = (state_q == S_FETCH) && !fifo_empty;
    assign underrun   = (state_q == S_FETCH) && fifo_empty;

    always_comb begin
        io_oe = 4'b0000;
        if (busy) begin
            case (lsh_q)
                2'd0:    io_oe = 4'b0001;
                2'd1:    io_oe = 4'b0011;
                default: io_oe = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_tx_shifter.sv
// Bench for qspi_tx_shifter: two instances (CLK_DIV 1 and 2) share one FIFO model;
// an expected-nibble queue built from the byte/lane rules is checked on every SCK rise.
module tb_qspi_tx_shifter;

    localparam int LW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    lane_mode = 2'b00;
    logic [LW-1:0] byte_len = '0;
    logic          stall = 1'b0;

    logic [31:0]   mem [0:15];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [31:0]   fifo_rd_data;
    logic          fifo_empty;
    assign fifo_empty = stall || (rd_ptr == wr_ptr);

    logic       rd_en_a, sck_a, busy_a, done_a, ur_a;
    logic [3:0] io_a, oe_a;
    logic       rd_en_b, sck_b, busy_b, done_b, ur_b;
    logic [3:0] io_b, oe_b;

    qspi_tx_shifter #(.DATA_WIDTH(32), .CLK_DIV(1), .LEN_WIDTH(LW)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .lane_mode(lane_mode),
        .byte_len(byte_len), .fifo_rd_en(rd_en_a), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty | sel), .sck(sck_a), .io_out(io_a), .io_oe(oe_a),
        .busy(busy_a), .done(done_a), .underrun(ur_a)
    );

    qspi_tx_shifter #(.DATA_WIDTH(32), .CLK_DIV(2), .LEN_WIDTH(LW)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .lane_mode(lane_mode),
        .byte_len(byte_len), .fifo_rd_en(rd_en_b), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty | ~sel), .sck(sck_b), .io_out(io_b), .io_oe(oe_b),
        .busy(busy_b), .done(done_b), .underrun(ur_b)
    );

    logic       fifo_rd_en, sck, busy, done, underrun;
    logic [3:0] io_out, io_oe;
    assign fifo_rd_en = sel ? rd_en_b : rd_en_a;
    assign sck        = sel ? sck_b   : sck_a;
    assign busy       = sel ? busy_b  : busy_a;
    assign done       = sel ? done_b  : done_a;
    assign underrun   = sel ? ur_b    : ur_a;
    assign io_out     = sel ? io_b    : io_a;
    assign io_oe      = sel ? oe_b    : oe_a;

    // Registered-read FIFO model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= 0;
            fifo_rd_data <= '0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 16];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state and trackers.
    logic [3:0]  exp_q [$];
    logic [3:0]  cap_q [$];
    logic [31:0] wq [$];
    logic [3:0]  exp_oe = 4'b0000;
    logic [3:0]  lit [8];
    int pops, dones, rises, underruns;
    int first_rise_cyc, done_cyc, busy_first_cyc;
    int t0;

    logic       prev_sck = 1'b0;
    logic [3:0] prev_io  = 4'b0000;

    always @(negedge clk) begin
        if (rst) begin
            prev_sck = 1'b0;
        end else begin
            if (!busy) begin
                check("idle_oe", 32'(io_oe), 32'h0);
                check("idle_io", 32'(io_out), 32'h0);
                check("idle_sck", 32'(sck), 32'h0);
            end else begin
                check("oe", 32'(io_oe), 32'(exp_oe));
                if (busy_first_cyc < 0) busy_first_cyc = cyc;
            end
            if (underrun) begin
                underruns++;
                check("underrun_sck", 32'(sck), 32'h0);
            end
            if (sck && !prev_sck) begin
                rises++;
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
                cap_q.push_back(io_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_sck_edge: got io %0h expected no edge (t=%0t)", io_out, $time);
                end else begin
                    check("lane_bits", 32'(io_out), 32'(exp_q.pop_front()));
                end
            end
            if (sck && prev_sck) check("io_stable_high", 32'(io_out), 32'(prev_io));
            if (fifo_rd_en) pops++;
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_sck = sck;
            prev_io  = io_out;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_trackers();
        pops = 0; dones = 0; rises = 0; underruns = 0;
        first_rise_cyc = -1; done_cyc = -1; busy_first_cyc = -1;
        cap_q.delete();
    endtask

    // Expected lane nibbles: each byte MSB first, highest lane carries the earliest bit.
    task automatic build_expect(input logic [1:0] mode, input int len);
        int m;
        int nl;
        logic [31:0] w;
        logic [7:0]  bval;
        logic [3:0]  nib;
        m  = (mode == 2'b11) ? 0 : int'(mode);
        nl = 1 << m;
        exp_oe = (m == 0) ? 4'b0001 : (m == 1) ? 4'b0011 : 4'b1111;
        for (int b = 0; b < len; b++) begin
            w    = wq[b / 4];
            bval = w[8 * (b % 4) +: 8];
            for (int c = 0; c < 8 / nl; c++) begin
                nib = 4'b0000;
                for (int l = 0; l < nl; l++) nib[nl - 1 - l] = bval[7 - c * nl - l];
                exp_q.push_back(nib);
            end
        end
    endtask

    task automatic begin_xfer(input logic s, input logic [1:0] mode, input int len);
        foreach (wq[i]) begin
            mem[wr_ptr % 16] = wq[i];
            wr_ptr++;
        end
        build_expect(mode, len);
        reset_trackers();
        sel       = s;
        lane_mode = mode;
        byte_len  = LW'(len);
        start     = 1'b1;
        t0        = cyc;
        tick(1);
        start     = 1'b0;
        lane_mode = 2'b01;
        byte_len  = LW'(7);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (dones == 0 && n < limit) begin
            tick(1);
            n++;
        end
        if (dones == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, limit);
        end
        tick(3);
        check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_cap(input string name, input int off, input int n);
        if (cap_q.size() < off + n) begin
            check({name, "_cap_size"}, 32'(cap_q.size()), 32'(off + n));
        end else begin
            for (int i = 0; i < n; i++)
                check($sformatf("%s_nib%0d", name, off + i), 32'(cap_q[off + i]), 32'(lit[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset_trackers();
        #2 rst = 1'b1;
        #1;
        check("rst_sck", 32'(sck), 32'h0);
        check("rst_io", 32'(io_out), 32'h0);
        check("rst_oe", 32'(io_oe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
        check("rst_underrun", 32'(underrun), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // Quad, 4 bytes, CLK_DIV=1.
        wq = '{32'h44332211};
        begin_xfer(1'b0, 2'b10, 4);
        wait_done("quad4", 100);
        lit = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
        check_cap("quad4", 0, 8);
        check("quad4_rises", 32'(rises), 32'd8);
        check("quad4_pops", 32'(pops), 32'd1);
        check("quad4_dones", 32'(dones), 32'd1);
        check("quad4_done_cyc", 32'(done_cyc - t0), 32'd19);
        check("quad4_first_rise", 32'(first_rise_cyc - t0), 32'd4);
        check("quad4_busy_first", 32'(busy_first_cyc - t0), 32'd1);

        // Quad, 1 byte, CLK_DIV=1.
        wq = '{32'hFFFF_FFC3};
        begin_xfer(1'b0, 2'b10, 1);
        wait_done("quad1", 50);
        lit = '{4'hC, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_cap("quad1", 0, 2);
        check("quad1_rises", 32'(rises), 32'd2);
        check("quad1_done_cyc", 32'(done_cyc - t0), 32'd7);
        check("quad1_first_rise", 32'(first_rise_cyc - t0), 32'd4);

        // Single, 1 byte: bytes 1-3 are discarded.
        wq = '{32'h000000A5};
        begin_xfer(1'b0, 2'b00, 1);
        wait_done("single1", 100);
        lit = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
        check_cap("single1", 0, 8);
        check("single1_pops", 32'(pops), 32'd1);
        check("single1_rises", 32'(rises), 32'd8);

        // Dual, 6 bytes, CLK_DIV=2, with a 5-cycle FIFO stall between words.
        wq = '{32'hDEADBEEF, 32'hFFFF5A3C};
        begin_xfer(1'b1, 2'b01, 6);
        begin
            int n = 0;
            while (pops < 1 && n < 50) begin tick(1); n++; end
            check("dual_first_pop_seen", 32'(pops), 32'd1);
            stall = 1'b1;
            n = 0;
            while (!underrun && n < 200) begin tick(1); n++; end
            check("dual_underrun_seen", 32'(underrun), 32'd1);
            tick(5);
            stall = 1'b0;
        end
        wait_done("dual6", 300);
        check("dual6_underruns", 32'(underruns), 32'd5);
        check("dual6_pops", 32'(pops), 32'd2);
        check("dual6_rises", 32'(rises), 32'd24);
        lit = '{4'h3, 4'h2, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        check_cap("dual6_w0", 0, 4);
        lit = '{4'h0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        check_cap("dual6_w1", 16, 4);

        // start with byte_len=0 is ignored.
        reset_trackers();
        sel = 1'b0; lane_mode = 2'b10; byte_len = '0; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        check("len0_pops", 32'(pops), 32'd0);
        check("len0_busy", 32'(busy_first_cyc), 32'hFFFF_FFFF);

        // lane_mode=11 acts as single; a start pulse mid-transfer changes nothing.
        wq = '{32'hFF0F817E};
        begin_xfer(1'b1, 2'b11, 3);
        tick(20);
        lane_mode = 2'b10; byte_len = LW'(1); start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("mode3", 300);
        check("mode3_pops", 32'(pops), 32'd1);
        check("mode3_rises", 32'(rises), 32'd24);
        check("mode3_dones", 32'(dones), 32'd1);
        lit = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        check_cap("mode3", 0, 8);

        // Reset mid-SHIFT, then a fresh 2-byte transfer.
        wq = '{32'h12345678};
        begin_xfer(1'b0, 2'b10, 4);
        begin
            int n = 0;
            while (rises < 3 && n < 50) begin tick(1); n++; end
            check("rst_mid_reached", 32'(rises), 32'd3);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_sck", 32'(sck), 32'h0);
        check("rst_mid_oe", 32'(io_oe), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        exp_q.delete();
        wr_ptr = 0;
        tick(2);
        rst = 1'b0;
        tick(4);
        check("rst_mid_no_done", 32'(dones), 32'd0);
        wq = '{32'hFFFF3CC3};
        begin_xfer(1'b0, 2'b10, 2);
        wait_done("post_rst", 100);
        lit = '{4'hC, 4'h3, 4'h3, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
        check_cap("post_rst", 0, 4);
        check("post_rst_pops", 32'(pops), 32'd1);
        check("post_rst_dones", 32'(dones), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
